score_level_tracker: RTL and testbench

Parametrised BCD score / level tracker for the obstacle game, the next generation of the level/score block. It counts cleared obstacles into an N-digit saturating BCD score, advances the level every PTS_PER_LEVEL points up to a cap, and owns the pause/adjust/game-over state machine. It also keeps a high-score register that survives game restarts. It sits between the obstacle/collision logic (tick, game_over) and the seven-segment display mux (score_bcd, level_bcd, hi_bcd).

---
 rtl/score_level_tracker.sv | 216 +++++++++++++++++++++
 tb/tb_score_level_tracker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_level_tracker.sv
// score_level_tracker: saturating BCD score, level progression, high score and
// the RUN/PAUSED/ADJUST/OVER game state machine for the obstacle game.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   tick       one-cycle pulse, one obstacle cleared
//   pause_btn  one-cycle pulse, toggle pause
//   adj        level-adjust mode request (level-sensitive)
//   lvl_sel    requested start level, binary
//   game_over  one-cycle pulse, collision
//   start      one-cycle pulse, new game after game over
//   score_bcd  score, packed BCD, digit 0 in LSBs
//   level_bin  current level, binary
//   level_bcd  current level as two BCD digits (decoded from level register)
//   hi_bcd     high score, packed BCD
//   paused     high in PAUSED or ADJUST
//   over       high in OVER
//   level_up   one-cycle pulse on level advance
//   new_high   high in OVER when the last game beat the high score
module score_level_tracker #(
  parameter int unsigned SCORE_DIGITS  = 4,
  parameter int unsigned MAX_LEVEL     = 15,
  parameter int unsigned PTS_PER_LEVEL = 10,
  // Derived width of binary level fields; leave at default.
  parameter int unsigned LW            = $clog2(MAX_LEVEL + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      pause_btn,
  input  logic                      adj,
  input  logic [LW-1:0]             lvl_sel,
  input  logic                      game_over,
  input  logic                      start,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [LW-1:0]             level_bin,
  output logic [7:0]                level_bcd,
  output logic [4*SCORE_DIGITS-1:0] hi_bcd,
  output logic                      paused,
  output logic                      over,
  output logic                      level_up,
  output logic                      new_high
);

  localparam int unsigned SW = 4 * SCORE_DIGITS;
  localparam int unsigned PW = (PTS_PER_LEVEL > 1) ? $clog2(PTS_PER_LEVEL) : 1;

  localparam logic [LW-1:0] LVL_MAX  = LW'(MAX_LEVEL);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTS_LAST = PW'(PTS_PER_LEVEL - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] score, score_n;
  logic [SW-1:0] hi, hi_n;
  logic [LW-1:0] level, level_n;
  logic [PW-1:0] pts, pts_n;
  logic          paused_n, over_n, level_up_n, new_high_n;

  logic [SW-1:0] score_inc;
  logic [PW-1:0] pts_inc;
  logic          pts_wrap;
  logic [7:0]    lvl8;

  // Decimal increment with ripple carry; all-nines saturates instead of wrapping.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) r = v;
    return r;
  endfunction

  // Clamp a requested level into 1..MAX_LEVEL.
  function automatic logic [LW-1:0] lvl_clamp(input logic [LW-1:0] v);
    logic [LW-1:0] r;
    if (v == '0)          r = LVL_ONE;
    else if (v > LVL_MAX) r = LVL_MAX;
    else                  r = v;
    return r;
  endfunction

  // Tick arithmetic shared by the RUN branch.
  always_comb begin
    score_inc = bcd_inc(score);
    pts_wrap  = (pts == PTS_LAST);
    pts_inc   = pts_wrap ? '0 : pts + PW'(1);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    score_n    = score;
    hi_n       = hi;
    level_n    = level;
    pts_n      = pts;
    new_high_n = new_high;
    level_up_n = 1'b0;

    case (state)
      RUN: begin
        if (game_over) begin
          state_n = OVER;
          if (score > hi) begin
            hi_n       = score;
            new_high_n = 1'b1;
          end
        end else begin
          if (tick) begin
            score_n = score_inc;
            pts_n   = pts_inc;
            if (pts_wrap && (level < LVL_MAX)) begin
              level_n    = level + LW'(1);
              level_up_n = 1'b1;
            end
          end
          if (pause_btn) state_n = PAUSED;
        end
      end

      PAUSED: begin
        if (game_over) begin
          state_n = OVER;
          if (score > hi) begin
            hi_n       = score;
            new_high_n = 1'b1;
          end
        end else if (adj) begin
          state_n = ADJUST;
        end else if (pause_btn) begin
          state_n = RUN;
        end
      end

      ADJUST: begin
        // Load only while adj is still high, so the falling-edge sample is dropped.
        if (adj) begin
          level_n = lvl_clamp(lvl_sel);
          score_n = '0;
          pts_n   = '0;
        end else begin
          state_n = PAUSED;
        end
      end

      OVER: begin
        if (start) begin
          score_n    = '0;
          level_n    = LVL_ONE;
          pts_n      = '0;
          new_high_n = 1'b0;
          state_n    = PAUSED;
        end
      end

      default: state_n = RUN;
    endcase

    paused_n = (state_n == PAUSED) || (state_n == ADJUST);
    over_n   = (state_n == OVER);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      score    <= '0;
      hi       <= '0;
      level    <= LVL_ONE;
      pts      <= '0;
      paused   <= 1'b0;
      over     <= 1'b0;
      level_up <= 1'b0;
      new_high <= 1'b0;
    end else begin
      state    <= state_n;
      score    <= score_n;
      hi       <= hi_n;
      level    <= level_n;
      pts      <= pts_n;
      paused   <= paused_n;
      over     <= over_n;
      level_up <= level_up_n;
      new_high <= new_high_n;
    end
  end

  assign score_bcd = score;
  assign hi_bcd    = hi;
  assign level_bin = level;

  // Two-digit decimal view of the level register for the display mux.
  always_comb begin
    lvl8      = 8'(level);
    level_bcd = {4'(lvl8 / 8'd10), 4'(lvl8 % 8'd10)};
  end

endmodule

// File: tb/tb_score_level_tracker.sv
// Scoreboard bench for score_level_tracker (2-digit score, MAX_LEVEL 12, 10 points/level).
module tb_score_level_tracker;

  localparam int unsigned TB_DIGITS = 2;
  localparam int unsigned TB_MAXLVL = 12;
  localparam int unsigned TB_PTS    = 10;
  localparam int unsigned TB_LW     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick, pause_btn, adj, game_over, start;
  logic [TB_LW-1:0] lvl_sel;
  logic [7:0]       score_bcd, hi_bcd, level_bcd;
  logic [TB_LW-1:0] level_bin;
  logic             paused, over, level_up, new_high;

  score_level_tracker #(
    .SCORE_DIGITS (TB_DIGITS),
    .MAX_LEVEL    (TB_MAXLVL),
    .PTS_PER_LEVEL(TB_PTS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .pause_btn(pause_btn),
    .adj      (adj),
    .lvl_sel  (lvl_sel),
    .game_over(game_over),
    .start    (start),
    .score_bcd(score_bcd),
    .level_bin(level_bin),
    .level_bcd(level_bcd),
    .hi_bcd   (hi_bcd),
    .paused   (paused),
    .over     (over),
    .level_up (level_up),
    .new_high (new_high)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      nm;
    logic [7:0] sc;
    logic [3:0] lv;
    logic [7:0] lb;
    logic [7:0] hi;
    logic       p;
    logic       o;
    logic       lu;
    logic       nh;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd2(input int v);
    int w;
    w = (v > 99) ? 99 : v;
    return {4'(w / 10), 4'(w % 10)};
  endfunction

  function automatic logic [3:0] exp_lvl(input int i, input int lv0);
    int l;
    l = lv0 + i / 10;
    if (l > int'(TB_MAXLVL)) l = int'(TB_MAXLVL);
    return 4'(l);
  endfunction

  function automatic logic exp_lu(input int i, input int lv0);
    return (i > 0) && (i % 10 == 0) && (lv0 + i / 10 <= int'(TB_MAXLVL));
  endfunction

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, f, act, exp, cyc);
    end
  endtask

  // Scoreboard push: expected DUT state for the current cycle.
  task automatic expect_st(input string nm, input logic [7:0] sc, input logic [3:0] lv,
                           input logic [7:0] hi, input logic p, input logic o,
                           input logic lu, input logic nh);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.sc = sc; e.lv = lv; e.lb = bcd2(int'(lv));
    e.hi = hi; e.p = p; e.o = o; e.lu = lu; e.nh = nh;
    q.push_back(e);
  endtask

  // Monitor: pops expectations due this cycle and compares on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      if (me.cyc != cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s.stale: got cycle %0d expected cycle %0d", me.nm, cyc, me.cyc);
      end else begin
        chk(me.nm, "score",     32'(score_bcd), 32'(me.sc));
        chk(me.nm, "level",     32'(level_bin), 32'(me.lv));
        chk(me.nm, "level_bcd", 32'(level_bcd), 32'(me.lb));
        chk(me.nm, "hi",        32'(hi_bcd),    32'(me.hi));
        chk(me.nm, "paused",    32'(paused),    32'(me.p));
        chk(me.nm, "over",      32'(over),      32'(me.o));
        chk(me.nm, "level_up",  32'(level_up),  32'(me.lu));
        chk(me.nm, "new_high",  32'(new_high),  32'(me.nh));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back ticks in RUN; i counts ticks since points were last cleared.
  task automatic run_ticks(input string nm, input int i0, input int i1, input int lv0,
                           input logic [7:0] hi, input logic nh);
    for (int i = i0; i <= i1; i++) begin
      tick = 1'b1;
      step();
      expect_st(nm, bcd2(i), exp_lvl(i, lv0), hi, 1'b0, 1'b0, exp_lu(i, lv0), nh);
    end
    tick = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; pause_btn = 1'b0; adj = 1'b0;
    game_over = 1'b0; start = 1'b0; lvl_sel = '0;
    #2 rst = 1'b0;

    // Reset state
    step(); expect_st("reset",      8'h00, 4'd1, 8'h00, 0, 0, 0, 0);
    step(); expect_st("reset_hold", 8'h00, 4'd1, 8'h00, 0, 0, 0, 0);
    #2 rst = 1'b1;
    step(); expect_st("idle",       8'h00, 4'd1, 8'h00, 0, 0, 0, 0);

    // 27 ticks: level_up on ticks 10 and 20
    run_ticks("count27", 1, 27, 1, 8'h00, 1'b0);
    step(); expect_st("count27_end", 8'h27, 4'd3, 8'h00, 0, 0, 0, 0);

    // pause_btn with tick: tick still counted, then ticks ignored
    tick = 1'b1; pause_btn = 1'b1;
    step(); pause_btn = 1'b0;
    expect_st("pause_tick", 8'h28, 4'd3, 8'h00, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(); expect_st("paused_ignore", 8'h28, 4'd3, 8'h00, 1, 0, 0, 0);
    end
    tick = 1'b0;

    // ADJUST: load 1, 5, clamp 15->12; falling-cycle value discarded
    adj = 1'b1; lvl_sel = 4'd0;
    step(); expect_st("adj_enter", 8'h28, 4'd3,  8'h00, 1, 0, 0, 0);
    step(); expect_st("adj_lv1",   8'h00, 4'd1,  8'h00, 1, 0, 0, 0);
    lvl_sel = 4'd5;
    step(); expect_st("adj_lv5",   8'h00, 4'd5,  8'h00, 1, 0, 0, 0);
    lvl_sel = 4'd15;
    step(); expect_st("adj_clamp", 8'h00, 4'd12, 8'h00, 1, 0, 0, 0);
    tick = 1'b1; pause_btn = 1'b1; game_over = 1'b1;
    step(); expect_st("adj_ignore", 8'h00, 4'd12, 8'h00, 1, 0, 0, 0);
    tick = 1'b0; pause_btn = 1'b0; game_over = 1'b0;
    adj = 1'b0; lvl_sel = 4'd3;
    step(); expect_st("adj_exit",  8'h00, 4'd12, 8'h00, 1, 0, 0, 0);
    step(); expect_st("adj_after", 8'h00, 4'd12, 8'h00, 1, 0, 0, 0);
    lvl_sel = 4'd0;

    // Resume at level 12; level holds at the cap with no level_up
    pulse_pause(); expect_st("resume", 8'h00, 4'd12, 8'h00, 0, 0, 0, 0);
    run_ticks("capped", 1, 42, 12, 8'h00, 1'b0);

    // Game 1 ends at 42: new high score
    game_over = 1'b1;
    step(); game_over = 1'b0;
    expect_st("over1", 8'h42, 4'd12, 8'h42, 0, 1, 0, 1);
    tick = 1'b1; pause_btn = 1'b1;
    step(); expect_st("over_ignore", 8'h42, 4'd12, 8'h42, 0, 1, 0, 1);
    pause_btn = 1'b0;
    step(); expect_st("over_hold",   8'h42, 4'd12, 8'h42, 0, 1, 0, 1);
    tick = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    expect_st("start1", 8'h00, 4'd1, 8'h42, 1, 0, 0, 0);

    // Game 2 ends at 17: high score unchanged
    pulse_pause(); expect_st("run2", 8'h00, 4'd1, 8'h42, 0, 0, 0, 0);
    run_ticks("game2", 1, 17, 1, 8'h42, 1'b0);
    game_over = 1'b1;
    step(); game_over = 1'b0;
    expect_st("over2", 8'h17, 4'd2, 8'h42, 0, 1, 0, 0);

    // Game 3 ties the high score: no update
    start = 1'b1;
    step(); start = 1'b0;
    expect_st("start2", 8'h00, 4'd1, 8'h42, 1, 0, 0, 0);
    pulse_pause(); expect_st("run3", 8'h00, 4'd1, 8'h42, 0, 0, 0, 0);
    run_ticks("game3", 1, 42, 1, 8'h42, 1'b0);
    game_over = 1'b1;
    step(); game_over = 1'b0;
    expect_st("over3_equal", 8'h42, 4'd5, 8'h42, 0, 1, 0, 0);

    // Saturation at 99 while points and level keep advancing to the cap
    start = 1'b1;
    step(); start = 1'b0;
    expect_st("start3", 8'h00, 4'd1, 8'h42, 1, 0, 0, 0);
    pulse_pause(); expect_st("run4", 8'h00, 4'd1, 8'h42, 0, 0, 0, 0);
    run_ticks("sat", 1, 120, 1, 8'h42, 1'b0);

    // Asynchronous reset mid-game, between clock edges
    tick = 1'b1;
    step(); expect_st("pre_rst", 8'h99, 4'd12, 8'h42, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    #1 expect_st("async_rst", 8'h00, 4'd1, 8'h00, 0, 0, 0, 0);
    step(); expect_st("rst_held", 8'h00, 4'd1, 8'h00, 0, 0, 0, 0);
    tick = 1'b0;
    #2 rst = 1'b1;
    step(); expect_st("rst_release", 8'h00, 4'd1, 8'h00, 0, 0, 0, 0);
    tick = 1'b1;
    step(); tick = 1'b0;
    expect_st("post_rst_tick", 8'h01, 4'd1, 8'h00, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && q.size() > 0; k++) step();
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
